// File: rtl/lock_ctrl_param_if.sv
// Keypad-side and display/door-side signals of the parametrised lock controller.
// All inputs are one-cycle strobes or levels sampled at posedge clk; there is no back-pressure.
interface lock_ctrl_param_if #(
   parameter int DIGITS = 6,
   parameter int SW     = 2
);
   // Strobes (key_valid, enter, cancel) are valid for exactly the cycle they are high and are
   // consumed unconditionally; the controller never stalls the keypad, so no ready exists.
   logic                mode;
   logic [SW-1:0]       slot_sel;
   logic                key_valid;
   logic [3:0]          key_digit;
   logic                enter;
   logic                cancel;
   logic                hide;
   logic [4*DIGITS-1:0] disp;
   logic                unlocked;
   logic                set_ok;
   logic                entry_err;
   logic [3:0]          fail_cnt;
   logic                locked_out;
   logic                led;
   logic [2:0]          dbg_state;

   modport master (
      output mode, slot_sel, key_valid, key_digit, enter, cancel, hide,
      input  disp, unlocked, set_ok, entry_err, fail_cnt, locked_out, led, dbg_state
   );

   modport slave (
      input  mode, slot_sel, key_valid, key_digit, enter, cancel, hide,
      output disp, unlocked, set_ok, entry_err, fail_cnt, locked_out, led, dbg_state
   );
endinterface

// File: rtl/lock_ctrl_param.sv
// Digit-serial keypad lock: SLOTS stored passwords of DIGITS digits, program and unlock modes,
// failure counting with a timed, LED-flashing lockout.
module lock_ctrl_param #(
   parameter int DIGITS      = 6,
   parameter int SLOTS       = 4,
   parameter int MAX_FAIL    = 3,
   parameter int LOCK_CYCLES = 1000,
   parameter int FLASH_HALF  = 25
) (
   input  logic clk,
   input  logic clr,
   lock_ctrl_param_if.slave bus
);
   localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int CW = $clog2(DIGITS + 1);
   localparam int LW = $clog2(LOCK_CYCLES);
   localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
   localparam int EW = 4 * DIGITS;

   typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_LOCKOUT} state_e;

   state_e            state_q, state_d;
   logic [EW-1:0]     entry_q, entry_d;
   logic [CW-1:0]     count_q, count_d;
   logic              bad_q, bad_d;
   logic [3:0]        fail_q, fail_d;
   logic              set_ok_q, set_ok_d;
   logic              err_q, err_d;
   logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
   logic [FW-1:0]     flash_cnt_q, flash_cnt_d;
   logic              led_q, led_d;
   logic [EW-1:0]     slot_q [SLOTS];
   logic [EW-1:0]     slot_d [SLOTS];
   logic [SLOTS-1:0]  prog_q, prog_d;

   logic              match;
   logic              key_ok;
   logic              clear_entry;
   logic              fail_event;
   logic [EW-1:0]     disp_c;

   // Unprogrammed slots hold zeros and must never match an all-zero entry.
   always_comb begin
      match = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
         if (prog_q[s] && (slot_q[s] == entry_q)) match = 1'b1;
      end
   end

   assign key_ok = (bus.key_digit <= 4'd9);

   always_comb begin
      state_d     = state_q;
      entry_d     = entry_q;
      count_d     = count_q;
      bad_d       = bad_q;
      fail_d      = fail_q;
      set_ok_d    = 1'b0;
      err_d       = 1'b0;
      lock_cnt_d  = lock_cnt_q;
      flash_cnt_d = flash_cnt_q;
      led_d       = led_q;
      slot_d      = slot_q;
      prog_d      = prog_q;
      clear_entry = 1'b0;
      fail_event  = 1'b0;

      case (state_q)
         S_LOCKOUT: begin
            if (lock_cnt_q == '0) begin
               state_d     = S_IDLE;
               fail_d      = '0;
               led_d       = 1'b0;
               flash_cnt_d = '0;
            end else begin
               lock_cnt_d = lock_cnt_q - LW'(1);
               if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
                  flash_cnt_d = '0;
                  led_d       = ~led_q;
               end else begin
                  flash_cnt_d = flash_cnt_q + FW'(1);
               end
            end
         end

         S_CHECK: begin
            clear_entry = 1'b1;
            if (bus.cancel) begin
               state_d = S_IDLE;
            end else if (match) begin
               state_d = S_OPEN;
               fail_d  = '0;
            end else begin
               fail_event = 1'b1;
            end
         end

         default: begin
            if (bus.cancel) begin
               clear_entry = 1'b1;
               state_d     = S_IDLE;
            end else if (bus.enter) begin
               // enter while open is swallowed; it still outranks a same-cycle key
               if (state_q != S_OPEN) begin
                  if ((count_q != CW'(DIGITS)) || bad_q) begin
                     err_d       = 1'b1;
                     clear_entry = 1'b1;
                     state_d     = S_IDLE;
                     fail_event  = bus.mode;
                  end else if (!bus.mode) begin
                     for (int s = 0; s < SLOTS; s++) begin
                        if (SW'(s) == bus.slot_sel) begin
                           slot_d[s] = entry_q;
                           prog_d[s] = 1'b1;
                        end
                     end
                     set_ok_d    = 1'b1;
                     clear_entry = 1'b1;
                     state_d     = S_IDLE;
                  end else begin
                     state_d = S_CHECK;
                  end
               end
            end else if (bus.key_valid) begin
               if (count_q < CW'(DIGITS)) begin
                  for (int i = DIGITS - 1; i > 0; i--) begin
                     entry_d[4*i +: 4] = entry_q[4*(i-1) +: 4];
                  end
                  entry_d[3:0] = key_ok ? bus.key_digit : 4'hE;
                  count_d      = count_q + CW'(1);
                  if (!key_ok) bad_d = 1'b1;
               end
               state_d = S_ENTRY;
            end
         end
      endcase

      if (clear_entry) begin
         entry_d = '0;
         count_d = '0;
         bad_d   = 1'b0;
      end

      if (fail_event) begin
         err_d  = 1'b1;
         fail_d = fail_q + 4'd1;
         if ((fail_q + 4'd1) >= 4'(MAX_FAIL)) begin
            state_d     = S_LOCKOUT;
            lock_cnt_d  = LW'(LOCK_CYCLES - 1);
            flash_cnt_d = '0;
            led_d       = 1'b1;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_IDLE;
         entry_q     <= '0;
         count_q     <= '0;
         bad_q       <= 1'b0;
         fail_q      <= '0;
         set_ok_q    <= 1'b0;
         err_q       <= 1'b0;
         lock_cnt_q  <= '0;
         flash_cnt_q <= '0;
         led_q       <= 1'b0;
         slot_q      <= '{default: '0};
         prog_q      <= '0;
      end else begin
         state_q     <= state_d;
         entry_q     <= entry_d;
         count_q     <= count_d;
         bad_q       <= bad_d;
         fail_q      <= fail_d;
         set_ok_q    <= set_ok_d;
         err_q       <= err_d;
         lock_cnt_q  <= lock_cnt_d;
         flash_cnt_q <= flash_cnt_d;
         led_q       <= led_d;
         slot_q      <= slot_d;
         prog_q      <= prog_d;
      end
   end

   // Position i shows the i-th most recent digit; empty positions are blank.
   always_comb begin
      disp_c = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (CW'(i) < count_q) disp_c[4*i +: 4] = bus.hide ? 4'hE : entry_q[4*i +: 4];
      end
   end

   assign bus.disp       = disp_c;
   assign bus.unlocked   = (state_q == S_OPEN);
   assign bus.locked_out = (state_q == S_LOCKOUT);
   assign bus.set_ok     = set_ok_q;
   assign bus.entry_err  = err_q;
   assign bus.fail_cnt   = fail_q;
   assign bus.led        = led_q;
   assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_lock_ctrl_param.sv
// Bench for lock_ctrl_param: directed scenarios plus random traffic checked against a
// transaction-level model of the lock (digit queue, slot table, failure count).
module tb_lock_ctrl_param;
   localparam int DIGITS      = 6;
   localparam int SLOTS       = 4;
   localparam int MAX_FAIL    = 3;
   localparam int LOCK_CYCLES = 1000;
   localparam int FLASH_HALF  = 25;
   localparam int SW          = 2;
   localparam int EW          = 4 * DIGITS;

   logic clk = 1'b0;
   logic clr;
   int   n_vec = 0;
   int   n_err = 0;

   lock_ctrl_param_if #(.DIGITS(DIGITS), .SW(SW)) bus ();

   lock_ctrl_param #(
      .DIGITS(DIGITS), .SLOTS(SLOTS), .MAX_FAIL(MAX_FAIL),
      .LOCK_CYCLES(LOCK_CYCLES), .FLASH_HALF(FLASH_HALF)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   // reference model: entered digits oldest first, stored passwords, failure count
   logic [3:0] exp_q[$];
   logic [3:0] m_slot [SLOTS][DIGITS];
   bit         m_prog [SLOTS];
   int         m_fail;

   function automatic logic [EW-1:0] model_disp();
      logic [EW-1:0] d;
      int n;
      d = '1;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         if (bus.hide || exp_q[n-1-i] > 4'd9) d[4*i +: 4] = 4'hE;
         else d[4*i +: 4] = exp_q[n-1-i];
      end
      return d;
   endfunction

   function automatic bit model_bad();
      if (exp_q.size() != DIGITS) return 1'b1;
      foreach (exp_q[i]) if (exp_q[i] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit model_match();
      bit ok;
      for (int s = 0; s < SLOTS; s++) begin
         if (m_prog[s]) begin
            ok = 1'b1;
            for (int i = 0; i < DIGITS; i++) if (m_slot[s][i] != exp_q[i]) ok = 1'b0;
            if (ok) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      for (int s = 0; s < SLOTS; s++) m_prog[s] = 1'b0;
      m_fail = 0;
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      bus.key_digit = d;
      bus.key_valid = 1'b1;
      tick();
      bus.key_valid = 1'b0;
      if (exp_q.size() < DIGITS) exp_q.push_back(d);
      n_vec++; if (bus.disp !== model_disp()) begin n_err++; $display("FAIL key_disp: got %h want %h", bus.disp, model_disp()); end
      n_vec++; if (bus.unlocked !== 1'b0) begin n_err++; $display("FAIL key_unlocked: got %b want 0", bus.unlocked); end
   endtask

   task automatic cancel_entry();
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      exp_q.delete();
      n_vec++; if (bus.unlocked !== 1'b0) begin n_err++; $display("FAIL cancel_unlocked: got %b want 0", bus.unlocked); end
      n_vec++; if (bus.disp !== {EW{1'b1}}) begin n_err++; $display("FAIL cancel_disp: got %h want blank", bus.disp); end
      n_vec++; if (bus.fail_cnt !== 4'(m_fail)) begin n_err++; $display("FAIL cancel_fail_cnt: got %0d want %0d", bus.fail_cnt, m_fail); end
   endtask

   task automatic do_enter(input bit md, input int sel, output bit lo);
      bit exp_u;
      lo = 1'b0;
      exp_u = 1'b0;
      bus.mode     = md;
      bus.slot_sel = SW'(sel);
      bus.enter    = 1'b1;
      tick();
      bus.enter = 1'b0;
      if (model_bad()) begin
         if (md) begin m_fail++; lo = (m_fail >= MAX_FAIL); end
         n_vec++; if (bus.entry_err !== 1'b1) begin n_err++; $display("FAIL rej_err: got %b want 1", bus.entry_err); end
         n_vec++; if (bus.set_ok !== 1'b0) begin n_err++; $display("FAIL rej_set_ok: got %b want 0", bus.set_ok); end
      end else if (!md) begin
         for (int i = 0; i < DIGITS; i++) m_slot[sel][i] = exp_q[i];
         m_prog[sel] = 1'b1;
         n_vec++; if (bus.set_ok !== 1'b1) begin n_err++; $display("FAIL prog_set_ok: got %b want 1", bus.set_ok); end
         n_vec++; if (bus.entry_err !== 1'b0) begin n_err++; $display("FAIL prog_err: got %b want 0", bus.entry_err); end
      end else begin
         n_vec++; if (bus.unlocked !== 1'b0) begin n_err++; $display("FAIL check_cycle_unlocked: got %b want 0", bus.unlocked); end
         tick();
         if (model_match()) begin
            m_fail = 0;
            exp_u  = 1'b1;
         end else begin
            m_fail++;
            lo = (m_fail >= MAX_FAIL);
         end
         n_vec++; if (bus.entry_err !== !exp_u) begin n_err++; $display("FAIL check_err: got %b want %b", bus.entry_err, !exp_u); end
      end
      exp_q.delete();
      n_vec++; if (bus.unlocked !== exp_u) begin n_err++; $display("FAIL enter_unlocked: got %b want %b", bus.unlocked, exp_u); end
      n_vec++; if (bus.fail_cnt !== 4'(m_fail)) begin n_err++; $display("FAIL enter_fail_cnt: got %0d want %0d", bus.fail_cnt, m_fail); end
      n_vec++; if (bus.locked_out !== lo) begin n_err++; $display("FAIL enter_locked_out: got %b want %b", bus.locked_out, lo); end
      n_vec++; if (bus.disp !== {EW{1'b1}}) begin n_err++; $display("FAIL enter_disp: got %h want blank", bus.disp); end
      if (!lo) begin
         tick();
         n_vec++; if ((bus.entry_err | bus.set_ok) !== 1'b0) begin n_err++; $display("FAIL pulse_width: got err=%b set_ok=%b want 0", bus.entry_err, bus.set_ok); end
      end
   endtask

   // Called on the first lockout cycle; strobes thrown at the DUT must all be ignored.
   task automatic wait_lockout();
      bit exp_led;
      for (int k = 0; k < LOCK_CYCLES; k++) begin
         exp_led = ((k / FLASH_HALF) % 2) == 0;
         n_vec++; if (bus.locked_out !== 1'b1) begin n_err++; $display("FAIL lo_level[%0d]: got %b want 1", k, bus.locked_out); end
         n_vec++; if (bus.led !== exp_led) begin n_err++; $display("FAIL lo_led[%0d]: got %b want %b", k, bus.led, exp_led); end
         n_vec++; if (bus.disp !== {EW{1'b1}}) begin n_err++; $display("FAIL lo_disp[%0d]: got %h want blank", k, bus.disp); end
         bus.key_valid = 1'($urandom_range(0, 1));
         bus.key_digit = 4'($urandom_range(0, 15));
         bus.enter     = ($urandom_range(0, 7) == 0);
         bus.cancel    = ($urandom_range(0, 7) == 0);
         @(posedge clk);
         #1;
      end
      bus.key_valid = 1'b0;
      bus.enter     = 1'b0;
      bus.cancel    = 1'b0;
      m_fail = 0;
      n_vec++; if (bus.locked_out !== 1'b0) begin n_err++; $display("FAIL lo_expiry: got %b want 0", bus.locked_out); end
      n_vec++; if (bus.fail_cnt !== 4'd0) begin n_err++; $display("FAIL lo_fail_clear: got %0d want 0", bus.fail_cnt); end
      n_vec++; if (bus.led !== 1'b0) begin n_err++; $display("FAIL lo_led_off: got %b want 0", bus.led); end
   endtask

   task automatic press_random_pw();
      for (int i = 0; i < DIGITS; i++) press(4'($urandom_range(0, 9)));
   endtask

   task automatic press_slot(input int s);
      for (int i = 0; i < DIGITS; i++) press(m_slot[s][i]);
   endtask

   // scenario tasks
   task automatic test_reset(input string tag);
      clr = 1'b1;
      tick();
      model_reset();
      n_vec++; if (bus.disp !== {EW{1'b1}}) begin n_err++; $display("FAIL %s_disp: got %h want blank", tag, bus.disp); end
      n_vec++; if ({bus.unlocked, bus.set_ok, bus.entry_err, bus.locked_out, bus.led} !== 5'b0) begin
         n_err++; $display("FAIL %s_flags: got u=%b s=%b e=%b lo=%b led=%b want all 0", tag,
                           bus.unlocked, bus.set_ok, bus.entry_err, bus.locked_out, bus.led); end
      n_vec++; if (bus.fail_cnt !== 4'd0) begin n_err++; $display("FAIL %s_fail_cnt: got %0d want 0", tag, bus.fail_cnt); end
      clr = 1'b0;
   endtask

   task automatic test_unprogrammed();
      bit lo;
      for (int i = 0; i < DIGITS; i++) press(4'd0);
      do_enter(1'b1, 0, lo);
   endtask

   task automatic test_program_unlock();
      bit lo;
      for (int i = 1; i <= DIGITS; i++) press(4'(i));
      do_enter(1'b0, 2, lo);
      for (int i = 1; i <= DIGITS; i++) press(4'(i));
      do_enter(1'b1, 0, lo);
      cancel_entry();
      for (int s = 0; s < SLOTS; s++) begin
         if (s != 2) begin
            press_random_pw();
            do_enter(1'b0, s, lo);
         end
      end
      for (int s = SLOTS - 1; s >= 0; s--) begin
         press_slot(s);
         do_enter(1'b1, 0, lo);
      end
      cancel_entry();
   endtask

   task automatic test_bad_entry();
      bit lo;
      logic [3:0] keys [DIGITS];
      keys = '{4'd1, 4'd2, 4'hA, 4'd4, 4'd5, 4'd6};
      foreach (keys[i]) press(keys[i]);
      n_vec++; if (bus.disp[15:12] !== 4'hE) begin n_err++; $display("FAIL bad_nibble: got %h want e", bus.disp[15:12]); end
      bus.hide = 1'b1;
      #1;
      n_vec++; if (bus.disp !== {DIGITS{4'hE}}) begin n_err++; $display("FAIL hide_disp: got %h want all e", bus.disp); end
      bus.hide = 1'b0;
      do_enter(1'b0, 1, lo);
   endtask

   task automatic test_count();
      bit lo;
      for (int i = 0; i < DIGITS - 1; i++) press(4'($urandom_range(0, 9)));
      do_enter(1'b0, 0, lo);
      for (int i = 0; i < DIGITS + 1; i++) press(4'($urandom_range(0, 9)));
      bus.cancel    = 1'b1;
      bus.enter     = 1'b1;
      bus.key_valid = 1'b1;
      bus.mode      = 1'b1;
      tick();
      bus.cancel = 1'b0; bus.enter = 1'b0; bus.key_valid = 1'b0;
      exp_q.delete();
      n_vec++; if (bus.disp !== {EW{1'b1}}) begin n_err++; $display("FAIL cancel_prio_disp: got %h want blank", bus.disp); end
      tick();
      n_vec++; if ({bus.entry_err, bus.unlocked} !== 2'b00) begin n_err++; $display("FAIL cancel_prio_nocheck: got err=%b u=%b want 0", bus.entry_err, bus.unlocked); end
      n_vec++; if (bus.fail_cnt !== 4'(m_fail)) begin n_err++; $display("FAIL cancel_prio_fail: got %0d want %0d", bus.fail_cnt, m_fail); end
   endtask

   task automatic wrong_attempt(output bit lo);
      do begin
         exp_q.delete();
         for (int i = 0; i < DIGITS; i++) exp_q.push_back(4'($urandom_range(0, 9)));
      end while (model_match());
      begin
         logic [3:0] pw [DIGITS];
         foreach (pw[i]) pw[i] = exp_q[i];
         exp_q.delete();
         foreach (pw[i]) press(pw[i]);
      end
      do_enter(1'b1, 0, lo);
   endtask

   task automatic test_lockout();
      bit lo;
      lo = 1'b0;
      for (int a = 0; a < MAX_FAIL && !lo; a++) wrong_attempt(lo);
      n_vec++; if (lo !== 1'b1 || bus.locked_out !== 1'b1) begin n_err++; $display("FAIL lockout_entry: got %b want 1", bus.locked_out); end
      n_vec++; if (bus.fail_cnt !== 4'(MAX_FAIL)) begin n_err++; $display("FAIL lockout_fail_cnt: got %0d want %0d", bus.fail_cnt, MAX_FAIL); end
      wait_lockout();
   endtask

   task automatic test_reset_mid();
      bit lo;
      press_random_pw();
      do_enter(1'b0, 3, lo);
      press_slot(3);
      bus.mode  = 1'b1;
      bus.enter = 1'b1;
      tick();
      bus.enter = 1'b0;
      test_reset("rst_check");
      press_slot(3);
      do_enter(1'b1, 0, lo);
      lo = 1'b0;
      while (!lo) wrong_attempt(lo);
      repeat (10) tick();
      test_reset("rst_lockout");
      n_vec++; if (bus.locked_out !== 1'b0) begin n_err++; $display("FAIL rst_lockout_level: got %b want 0", bus.locked_out); end
   endtask

   task automatic test_random();
      bit lo;
      int op, s, n;
      for (int it = 0; it < 30; it++) begin
         op = $urandom_range(0, 9);
         bus.hide = ($urandom_range(0, 3) == 0);
         lo = 1'b0;
         if (op < 3) begin
            press_random_pw();
            do_enter(1'b0, $urandom_range(0, SLOTS - 1), lo);
         end else if (op < 7) begin
            s = $urandom_range(0, SLOTS - 1);
            if (m_prog[s] && op != 6) press_slot(s);
            else press_random_pw();
            do_enter(1'b1, 0, lo);
         end else if (op == 7) begin
            n = $urandom_range(0, DIGITS + 1);
            for (int i = 0; i < n; i++) press(4'($urandom_range(0, 15)));
            do_enter(1'($urandom_range(0, 1)), $urandom_range(0, SLOTS - 1), lo);
         end else begin
            n = $urandom_range(1, DIGITS);
            for (int i = 0; i < n; i++) press(4'($urandom_range(0, 9)));
            cancel_entry();
         end
         if (lo) wait_lockout();
      end
      bus.hide = 1'b0;
   endtask

   initial begin
      clr           = 1'b1;
      bus.mode      = 1'b0;
      bus.slot_sel  = '0;
      bus.key_valid = 1'b0;
      bus.key_digit = '0;
      bus.enter     = 1'b0;
      bus.cancel    = 1'b0;
      bus.hide      = 1'b0;
      model_reset();
      tick();
      test_reset("reset");
      test_unprogrammed();
      test_program_unlock();
      test_bad_entry();
      test_count();
      test_lockout();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
